seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter: NUM_DIGITS, default 10, number of multiplexed digits.
REQ-002 Parameter: PRESCALE_W, default 16, width of the dwell-time input.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset; it is synchronous and active-low, sampled on the rising edge of clk.
REQ-005 Port: enable  input  1  1 = scanning runs, 0 = display dark.
REQ-006 Port: prescale  input  PRESCALE_W  dwell cycles per digit, minus one.
REQ-007 Port: wr_en  input  1  write strobe for the message buffer.
REQ-008 Port: wr_addr  input  4  digit index to write.
REQ-009 Port: wr_data  input  8  segment pattern (bit7 = a ... bit1 = g, bit0 = dp).
REQ-010 Port: wr_err  output  1  one-cycle pulse; write rejected.
REQ-011 Port: sel  output  NUM_DIGITS  one-hot digit select; all-zero when dark.
REQ-012 Port: segm  output  8  segment pattern for the selected digit.
REQ-013 Port: frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-014 The block SHALL hold a NUM_DIGITS x 8 message buffer, written only through the wr_* port.
REQ-015 Write: wr_en=1 with wr_addr<NUM_DIGITS SHALL update buffer[wr_addr] at that edge; wr_addr>=NUM_DIGITS SHALL leave the buffer unchanged and assert wr_err for exactly the next cycle.
REQ-016 FSM states SHALL be IDLE, BLANK and DRIVE.
REQ-017 IDLE: sel=0, segm=0, digit index idx=0. Go to BLANK on the first cycle enable=1.
REQ-018 BLANK lasts exactly 1 cycle with sel=0, segm=0. It latches shadow=buffer[idx] and cnt_max=prescale, then goes to DRIVE.
REQ-019 DRIVE: sel=one-hot(idx) and segm=shadow for exactly cnt_max+1 cycles. When the dwell ends, idx advances, wrapping from NUM_DIGITS-1 to 0, and the FSM returns to BLANK.
REQ-020 frame_done SHALL pulse for exactly 1 cycle, in the cycle after the DRIVE that ends at idx=NUM_DIGITS-1.
REQ-021 A write to buffer[idx] in the same cycle as BLANK reads it SHALL be latched as the old value; the new value is shown on the next visit.
REQ-022 Changes to prescale during DRIVE SHALL NOT alter the current dwell.
REQ-023 enable=0 in any state SHALL force IDLE at the next edge, with sel=0, segm=0 and idx=0. This abandons the current dwell and produces no frame_done.
REQ-024 All outputs SHALL be registered; sel SHALL never have more than one bit set.
REQ-025 The dwell counter SHALL be PRESCALE_W wide. prescale=0 gives a 1-cycle dwell; all-ones gives 2^PRESCALE_W cycles.

Reset
REQ-026 With rst_n=0 at an edge, the block SHALL enter IDLE with idx=0, sel=0, segm=0, wr_err=0 and frame_done=0.
REQ-027 Reset SHALL load the buffer with the default message CE, FC, B6, FC, 9C, FC, DA, FC, FC, FC (hex, digits 0..9).
REQ-028 Reset asserted mid-DRIVE SHALL take priority over writes and enable in that cycle.

Structure
REQ-029 Package seg_scan_pkg SHALL hold the FSM state enum, NUM_DIGITS default and the default-message constant array.
REQ-030 The dwell counter SHALL be a sub-module scan_prescaler (load, count, terminal-count flag); the FSM, buffer and write logic stay in seg_scan_ctrl.

Verification
REQ-031 Reset, then enable=1 with prescale=0 -> sel pattern: 0, 001h (segm CE), 0, 002h (FC), 0, 004h (B6) ... 200h (FC), then frame_done=1 for one cycle; a full frame is 20 cycles.
REQ-032 prescale=3 -> each digit is driven for 4 cycles, separated by a 1-cycle blank; the frame is 50 cycles.
REQ-033 Write wr_addr=2, wr_data=60h while idx=2 is in DRIVE -> this frame still shows B6; the next frame shows 60 on digit 2.
REQ-034 Write wr_addr=12 -> wr_err pulses for 1 cycle and the buffer is unchanged across a full frame.
REQ-035 Drop enable during DRIVE of idx=5 -> the next cycle has sel=0 and no frame_done; re-enabling restarts at digit 0 with a blank first.
REQ-036 Assert rst_n=0 mid-frame after writes -> the outputs and buffer return to the REQ-026/REQ-027 values.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared definitions for the multiplexed seven-segment scanner:
//   - state_t        : scan FSM states (IDLE, BLANK, DRIVE)
//   - NUM_DIGITS_DEF : default number of multiplexed digits
//   - DEFAULT_MSG    : message loaded into the buffer on reset (digits 0..9)
//   - default_digit  : reset pattern for a digit index (blank past the message)
// -----------------------------------------------------------------------------
package seg_scan_pkg;

    localparam int NUM_DIGITS_DEF = 10;
    localparam int MSG_LEN        = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // Segment order is bit7 = a ... bit1 = g, bit0 = dp.
    localparam logic [7:0] DEFAULT_MSG [MSG_LEN] = '{
        8'hCE, 8'hFC, 8'hB6, 8'hFC, 8'h9C,
        8'hFC, 8'hDA, 8'hFC, 8'hFC, 8'hFC
    };

    // Digits beyond the stored message power up dark.
    function automatic logic [7:0] default_digit(input int i);
        logic [7:0] pat;
        pat = 8'h00;
        if (i >= 0 && i < MSG_LEN) begin
            pat = DEFAULT_MSG[4'(i)];
        end
        return pat;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Dwell-time down-counter for one digit.
//   i_load     : load i_load_val (takes priority over counting)
//   i_count    : decrement towards zero while asserted
//   o_tc       : terminal count, high while the counter sits at zero
// Loading N yields N+1 counting cycles up to and including the o_tc cycle, so
// an all-ones load gives a 2^W cycle dwell without needing a wider counter.
//   clk, i_rst_n : clock and synchronous active-low reset
// -----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_count,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Multiplexed seven-segment scan controller with a writable message buffer.
// Each digit visit is one dark BLANK cycle (anti-ghosting) followed by a DRIVE
// dwell of prescale+1 cycles; frame_done pulses in the BLANK after the last
// digit.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   enable        : 1 = scanning, 0 = dark and parked at digit 0
//   prescale      : dwell cycles per digit minus one, sampled in BLANK
//   wr_en/addr/data : message buffer write port
//   wr_err        : one-cycle pulse after a write to an out-of-range digit
//   sel           : one-hot digit select (all zero when dark)
//   segm          : segment pattern of the selected digit
//   frame_done    : one-cycle pulse at the end of each full scan
// wr_addr is 4 bits wide, so NUM_DIGITS must not exceed 16.
// -----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  wr_en,
    input  logic [3:0]            wr_addr,
    input  logic [7:0]            wr_data,
    output logic                  wr_err,
    output logic [NUM_DIGITS-1:0] sel,
    output logic [7:0]            segm,
    output logic                  frame_done
);

    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [7:0]              r_buf [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   r_sel;
    logic [7:0]              r_segm;
    logic                    r_wr_err;
    logic                    r_frame_done;

    logic                    w_wr_ok;
    logic [IDX_W-1:0]        w_wr_idx;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_load;
    logic                    w_count;
    logic                    w_tc;

    assign w_wr_ok  = (32'(wr_addr) < NUM_DIGITS);
    assign w_wr_idx = wr_addr[IDX_W-1:0];
    assign w_onehot = NUM_DIGITS'(1) << r_idx;

    // The dwell length is captured together with the digit pattern at the end
    // of BLANK, so prescale changes mid-dwell only affect the next visit.
    assign w_load  = enable && (r_state == ST_BLANK);
    assign w_count = (r_state == ST_DRIVE);

    scan_prescaler #(
        .W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_load     (w_load),
        .i_load_val (prescale),
        .i_count    (w_count),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_sel        <= '0;
            r_segm       <= '0;
            r_wr_err     <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_buf[IDX_W'(i)] <= default_digit(i);
            end
        end else begin
            r_wr_err     <= wr_en && !w_wr_ok;
            r_frame_done <= 1'b0;
            if (wr_en && w_wr_ok) begin
                r_buf[w_wr_idx] <= wr_data;
            end

            if (!enable) begin
                // Abandon any visit in progress; the next scan restarts at digit 0.
                r_state <= ST_IDLE;
                r_idx   <= '0;
                r_sel   <= '0;
                r_segm  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_BLANK;
                        r_sel   <= '0;
                        r_segm  <= '0;
                    end
                    ST_BLANK: begin
                        // Non-blocking read: a same-cycle write shows next visit.
                        r_state <= ST_DRIVE;
                        r_sel   <= w_onehot;
                        r_segm  <= r_buf[r_idx];
                    end
                    ST_DRIVE: begin
                        if (w_tc) begin
                            r_state      <= ST_BLANK;
                            r_sel        <= '0;
                            r_segm       <= '0;
                            r_frame_done <= (r_idx == LAST_IDX);
                            r_idx        <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_sel   <= '0;
                        r_segm  <= '0;
                    end
                endcase
            end
        end
    end

    assign wr_err     = r_wr_err;
    assign sel        = r_sel;
    assign segm       = r_segm;
    assign frame_done = r_frame_done;

endmodule
